readout_tx_pulse_sequencer_google: RTL and testbench

READOUT_TX_PULSE_SEQUENCER_GOOGLE -- requirements
Module: readout_tx_pulse_sequencer_google

---
 rtl/readout_tx_pulse_sequencer_google.sv | 132 +++++++++++++
 tb/tb_readout_tx_pulse_sequencer_google.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/readout_tx_pulse_sequencer_google.sv
// Readout TX pulse sequencer: plays a stored envelope once per trigger,
// upconverted to fs/4 by rotating each sample through the I/Q quadrants.
module readout_tx_pulse_sequencer_google #(
   parameter int unsigned DATA_WIDTH          = 8,
   parameter int unsigned ENVELOPE_ADDR_WIDTH = 4
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  envelope_wr_en,
   input  logic        [ENVELOPE_ADDR_WIDTH-1:0] envelope_wr_addr,
   input  logic signed [DATA_WIDTH-1:0]          envelope_wr_data,
   input  logic                                  pulse_length_wr_en,
   input  logic        [ENVELOPE_ADDR_WIDTH-1:0] pulse_length_wr_data,
   input  logic                                  trigger,
   output logic                                  busy,
   output logic                                  valid_out,
   output logic signed [DATA_WIDTH-1:0]          i_out,
   output logic signed [DATA_WIDTH-1:0]          q_out,
   output logic                                  start_count,
   output logic                                  finish_count
);

   localparam int unsigned AW    = ENVELOPE_ADDR_WIDTH;
   localparam int unsigned DW    = DATA_WIDTH;
   localparam int unsigned DEPTH = 1 << AW;

   localparam logic signed [DW-1:0] S_MIN = {1'b1, {(DW-1){1'b0}}};
   localparam logic signed [DW-1:0] S_MAX = {1'b0, {(DW-1){1'b1}}};

   typedef enum logic {IDLE, PLAY} state_t;

   state_t                state;
   logic [AW-1:0]         idx;         // index of the sample currently on the outputs
   logic [1:0]            phase;       // rotation quadrant of the sample on the outputs
   logic [AW-1:0]         length_reg;  // pulse length minus one
   logic signed [DW-1:0]  mem [DEPTH];

   logic [AW-1:0]         rd_idx;
   logic [1:0]            rd_phase;
   logic signed [DW-1:0]  env;
   logic signed [DW-1:0]  env_neg;
   logic signed [DW-1:0]  rot_i;
   logic signed [DW-1:0]  rot_q;

   // Envelope memory: cleared on reset, writable at any time
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned k = 0; k < DEPTH; k++) begin
            mem[k] <= '0;
         end
      end else if (envelope_wr_en) begin
         mem[envelope_wr_addr] <= envelope_wr_data;
      end
   end

   // Next sample to present: fetch, saturating negate and quadrant rotation
   always_comb begin
      rd_idx   = (state == PLAY) ? AW'(idx + AW'(1)) : '0;
      rd_phase = (state == PLAY) ? 2'(phase + 2'd1) : 2'd0;
      env      = mem[rd_idx];
      env_neg  = (env == S_MIN) ? S_MAX : -env;
      rot_i    = '0;
      rot_q    = '0;
      case (rd_phase)
         2'd0:    rot_i = env;
         2'd1:    rot_q = env;
         2'd2:    rot_i = env_neg;
         default: rot_q = env_neg;
      endcase
   end

   // Sequencer FSM with registered sample outputs and count strobes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         idx          <= '0;
         phase        <= 2'd0;
         length_reg   <= '1;
         busy         <= 1'b0;
         valid_out    <= 1'b0;
         i_out        <= '0;
         q_out        <= '0;
         start_count  <= 1'b0;
         finish_count <= 1'b0;
      end else begin
         start_count  <= 1'b0;
         finish_count <= 1'b0;
         case (state)
            IDLE: begin
               if (trigger) begin
                  state        <= PLAY;
                  idx          <= '0;
                  phase        <= 2'd0;
                  busy         <= 1'b1;
                  valid_out    <= 1'b1;
                  i_out        <= rot_i;
                  q_out        <= rot_q;
                  start_count  <= 1'b1;
                  finish_count <= (length_reg == '0);
               end else begin
                  if (pulse_length_wr_en) begin
                     length_reg <= pulse_length_wr_data;
                  end
                  busy      <= 1'b0;
                  valid_out <= 1'b0;
                  i_out     <= '0;
                  q_out     <= '0;
               end
            end
            PLAY: begin
               if (idx == length_reg) begin
                  state     <= IDLE;
                  idx       <= '0;
                  phase     <= 2'd0;
                  busy      <= 1'b0;
                  valid_out <= 1'b0;
                  i_out     <= '0;
                  q_out     <= '0;
               end else begin
                  idx          <= rd_idx;
                  phase        <= rd_phase;
                  i_out        <= rot_i;
                  q_out        <= rot_q;
                  finish_count <= (rd_idx == length_reg);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_readout_tx_pulse_sequencer_google.sv
// Testbench for readout_tx_pulse_sequencer_google: scenario tasks against a
// list-based model of the expected pulse (envelope, length, fs/4 rotation).
module tb_readout_tx_pulse_sequencer_google;

   localparam int DW    = 8;
   localparam int AW    = 4;
   localparam int DEPTH = 16;
   localparam int MAXV  = 127;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 envelope_wr_en = 1'b0;
   logic        [AW-1:0] envelope_wr_addr = '0;
   logic signed [DW-1:0] envelope_wr_data = '0;
   logic                 pulse_length_wr_en = 1'b0;
   logic        [AW-1:0] pulse_length_wr_data = '0;
   logic                 trigger = 1'b0;
   logic                 busy;
   logic                 valid_out;
   logic signed [DW-1:0] i_out;
   logic signed [DW-1:0] q_out;
   logic                 start_count;
   logic                 finish_count;

   always #5 clk = ~clk;

   readout_tx_pulse_sequencer_google #(.DATA_WIDTH(DW), .ENVELOPE_ADDR_WIDTH(AW)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .envelope_wr_en       (envelope_wr_en),
      .envelope_wr_addr     (envelope_wr_addr),
      .envelope_wr_data     (envelope_wr_data),
      .pulse_length_wr_en   (pulse_length_wr_en),
      .pulse_length_wr_data (pulse_length_wr_data),
      .trigger              (trigger),
      .busy                 (busy),
      .valid_out            (valid_out),
      .i_out                (i_out),
      .q_out                (q_out),
      .start_count          (start_count),
      .finish_count         (finish_count)
   );

   int n_checks = 0;
   int n_fail   = 0;

   int mdl_mem [DEPTH];
   int mdl_len;

   int cap_i [$];
   int cap_q [$];
   bit cap_s [$];
   bit cap_f [$];
   bit cap_b [$];

   // Reference: negation clamps at the most positive value
   function automatic int sat_neg(input int a);
      int r;
      r = -a;
      return (r > MAXV) ? MAXV : r;
   endfunction

   // Reference: fs/4 rotation of sample n with amplitude a
   function automatic int exp_i(input int a, input int n);
      case (n % 4)
         0:       return a;
         2:       return sat_neg(a);
         default: return 0;
      endcase
   endfunction

   function automatic int exp_q(input int a, input int n);
      case (n % 4)
         1:       return a;
         3:       return sat_neg(a);
         default: return 0;
      endcase
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset;
      foreach (mdl_mem[k]) mdl_mem[k] = 0;
      mdl_len = DEPTH - 1;
   endtask

   task automatic wr_env(input int a, input int d);
      envelope_wr_en   = 1'b1;
      envelope_wr_addr = AW'(a);
      envelope_wr_data = DW'(d);
      tick();
      envelope_wr_en   = 1'b0;
      mdl_mem[a]       = d;
   endtask

   task automatic wr_len(input int l);
      pulse_length_wr_en   = 1'b1;
      pulse_length_wr_data = AW'(l);
      tick();
      pulse_length_wr_en   = 1'b0;
      mdl_len              = l;
   endtask

   // Fire one trigger and record every valid sample; optional side writes
   // are issued while sample number len_at / env_at is on the outputs.
   task automatic capture(input bit hold, input bit len_with_trig, input int len_at,
                          input int len_val, input int env_at, input int env_addr,
                          input int env_data, output int n);
      cap_i.delete(); cap_q.delete(); cap_s.delete(); cap_f.delete(); cap_b.delete();
      trigger              = 1'b1;
      pulse_length_wr_en   = len_with_trig;
      pulse_length_wr_data = AW'(len_val);
      tick();
      trigger            = hold;
      pulse_length_wr_en = 1'b0;
      n = 0;
      while (valid_out === 1'b1 && n < 40) begin
         cap_i.push_back(int'(i_out));
         cap_q.push_back(int'(q_out));
         cap_s.push_back(start_count);
         cap_f.push_back(finish_count);
         cap_b.push_back(busy);
         if (n == len_at) begin
            pulse_length_wr_en   = 1'b1;
            pulse_length_wr_data = AW'(len_val);
         end
         if (n == env_at) begin
            envelope_wr_en   = 1'b1;
            envelope_wr_addr = AW'(env_addr);
            envelope_wr_data = DW'(env_data);
         end
         tick();
         pulse_length_wr_en = 1'b0;
         envelope_wr_en     = 1'b0;
         n++;
      end
   endtask

   task automatic test_reset;
      int n;
      rst = 1'b1;
      #1;
      n_checks++;
      if ({busy, valid_out, start_count, finish_count} !== 4'b0 || i_out !== 0 || q_out !== 0) begin
         n_fail++;
         $display("FAIL reset_outputs: busy=%b valid=%b start=%b finish=%b i=%0d q=%0d, want all 0",
                  busy, valid_out, start_count, finish_count, i_out, q_out);
      end
      tick();
      rst = 1'b0;
      model_reset();
      tick();
      capture(1'b0, 1'b0, -1, 0, -1, 0, 0, n);
      n_checks++;
      if (n !== mdl_len + 1) begin
         n_fail++;
         $display("FAIL reset_default_length: got %0d samples, want %0d", n, mdl_len + 1);
      end
      for (int j = 0; j < n; j++) begin
         n_checks++;
         if (cap_i[j] !== 0 || cap_q[j] !== 0) begin
            n_fail++;
            $display("FAIL reset_cleared_mem[%0d]: got (%0d,%0d), want (0,0)", j, cap_i[j], cap_q[j]);
         end
      end
   endtask

   task automatic test_basic;
      int n;
      int ei [4] = '{10, 0, -30, 0};
      int eq [4] = '{0, 20, 0, -40};
      wr_env(0, 10); wr_env(1, 20); wr_env(2, 30); wr_env(3, 40);
      wr_len(3);
      capture(1'b0, 1'b0, -1, 0, -1, 0, 0, n);
      n_checks++;
      if (n !== 4) begin
         n_fail++;
         $display("FAIL basic_len: got %0d samples, want 4", n);
      end
      for (int j = 0; j < n && j < 4; j++) begin
         n_checks++;
         if (cap_i[j] !== ei[j] || cap_q[j] !== eq[j] || cap_s[j] !== (j == 0) ||
             cap_f[j] !== (j == 3) || cap_b[j] !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_sample[%0d]: got i=%0d q=%0d s=%b f=%b b=%b, want i=%0d q=%0d s=%b f=%b b=1",
                     j, cap_i[j], cap_q[j], cap_s[j], cap_f[j], cap_b[j], ei[j], eq[j], j == 0, j == 3);
         end
      end
      n_checks++;
      if (busy !== 1'b0 || i_out !== 0 || q_out !== 0 || finish_count !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_idle: busy=%b i=%0d q=%0d finish=%b, want 0", busy, i_out, q_out, finish_count);
      end
   endtask

   task automatic test_saturation;
      int n;
      wr_env(0, -128);
      wr_env(2, -128);
      wr_len(2);
      capture(1'b0, 1'b0, -1, 0, -1, 0, 0, n);
      n_checks++;
      if (n !== 3 || cap_i[0] !== -128 || cap_q[0] !== 0) begin
         n_fail++;
         $display("FAIL sat_first: n=%0d i=%0d q=%0d, want n=3 i=-128 q=0", n, cap_i[0], cap_q[0]);
      end
      n_checks++;
      if (n !== 3 || cap_i[2] !== 127 || cap_q[2] !== 0) begin
         n_fail++;
         $display("FAIL sat_neg: i=%0d q=%0d, want i=127 q=0", cap_i[2], cap_q[2]);
      end
   endtask

   task automatic test_len_zero;
      int n;
      wr_env(0, 5);
      wr_len(0);
      capture(1'b0, 1'b0, -1, 0, -1, 0, 0, n);
      n_checks++;
      if (n !== 1 || cap_i[0] !== 5 || cap_q[0] !== 0 || cap_s[0] !== 1'b1 || cap_f[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL len_zero: n=%0d i=%0d q=%0d s=%b f=%b, want n=1 i=5 q=0 s=1 f=1",
                  n, cap_i[0], cap_q[0], cap_s[0], cap_f[0]);
      end
   endtask

   task automatic test_trigger_held;
      int n;
      int k;
      wr_len(15);
      capture(1'b1, 1'b0, -1, 0, -1, 0, 0, n);
      n_checks++;
      if (n !== 16 || valid_out !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL held_first_pulse: n=%0d then valid=%b busy=%b, want 16 then 0 0", n, valid_out, busy);
      end
      tick();
      n_checks++;
      if (valid_out !== 1'b1 || start_count !== 1'b1) begin
         n_fail++;
         $display("FAIL held_restart: valid=%b start=%b, want 1 1", valid_out, start_count);
      end
      trigger = 1'b0;
      k = 0;
      while (valid_out === 1'b1 && k < 40) begin
         tick();
         k++;
      end
      n_checks++;
      if (k !== 16) begin
         n_fail++;
         $display("FAIL held_second_pulse: got %0d samples, want 16", k);
      end
   endtask

   task automatic test_length_write_blocked;
      int n;
      wr_len(7);
      capture(1'b0, 1'b0, 2, 1, -1, 0, 0, n);
      n_checks++;
      if (n !== 8) begin
         n_fail++;
         $display("FAIL len_wr_play_cur: got %0d samples, want 8", n);
      end
      capture(1'b0, 1'b1, -1, 2, -1, 0, 0, n);
      n_checks++;
      if (n !== 8) begin
         n_fail++;
         $display("FAIL len_wr_play_next: got %0d samples, want 8", n);
      end
      tick();
      capture(1'b0, 1'b0, -1, 0, -1, 0, 0, n);
      n_checks++;
      if (n !== 8) begin
         n_fail++;
         $display("FAIL len_wr_with_trigger: got %0d samples, want 8", n);
      end
   endtask

   task automatic test_collision;
      int n;
      int newv;
      for (int a = 0; a < 8; a++) wr_env(a, int'($urandom_range(0, 255)) - 128);
      newv = int'($urandom_range(0, 255)) - 128;
      // write address 3 while sample 2 shows, i.e. while address 3 is being fetched
      capture(1'b0, 1'b0, -1, 0, 2, 3, newv, n);
      n_checks++;
      if (n !== mdl_len + 1) begin
         n_fail++;
         $display("FAIL collide_len: got %0d, want %0d", n, mdl_len + 1);
      end
      for (int j = 0; j < n && j <= mdl_len; j++) begin
         n_checks++;
         if (cap_i[j] !== exp_i(mdl_mem[j], j) || cap_q[j] !== exp_q(mdl_mem[j], j)) begin
            n_fail++;
            $display("FAIL collide_old[%0d]: got (%0d,%0d), want (%0d,%0d)", j, cap_i[j], cap_q[j],
                     exp_i(mdl_mem[j], j), exp_q(mdl_mem[j], j));
         end
      end
      mdl_mem[3] = newv;
      tick();
      capture(1'b0, 1'b0, -1, 0, -1, 0, 0, n);
      n_checks++;
      if (n < 4 || cap_i[3] !== exp_i(newv, 3) || cap_q[3] !== exp_q(newv, 3)) begin
         n_fail++;
         $display("FAIL collide_new: n=%0d sample3=(%0d,%0d), want (%0d,%0d)", n, cap_i[3], cap_q[3],
                  exp_i(newv, 3), exp_q(newv, 3));
      end
   endtask

   task automatic test_random;
      int n;
      for (int it = 0; it < 5; it++) begin
         for (int a = 0; a < DEPTH; a++) wr_env(a, int'($urandom_range(0, 255)) - 128);
         if (it == 0) wr_env(int'($urandom_range(0, 15)), -128);
         wr_len(int'($urandom_range(0, 15)));
         capture(1'b0, 1'b0, -1, 0, -1, 0, 0, n);
         n_checks++;
         if (n !== mdl_len + 1) begin
            n_fail++;
            $display("FAIL rand%0d_len: got %0d, want %0d", it, n, mdl_len + 1);
         end
         for (int j = 0; j < n && j <= mdl_len; j++) begin
            n_checks++;
            if (cap_i[j] !== exp_i(mdl_mem[j], j) || cap_q[j] !== exp_q(mdl_mem[j], j) ||
                cap_s[j] !== (j == 0) || cap_f[j] !== (j == mdl_len) || cap_b[j] !== 1'b1) begin
               n_fail++;
               $display("FAIL rand%0d_sample[%0d]: got i=%0d q=%0d s=%b f=%b b=%b, want i=%0d q=%0d s=%b f=%b b=1",
                        it, j, cap_i[j], cap_q[j], cap_s[j], cap_f[j], cap_b[j],
                        exp_i(mdl_mem[j], j), exp_q(mdl_mem[j], j), j == 0, j == mdl_len);
            end
         end
      end
   endtask

   task automatic test_reset_mid_pulse;
      int n;
      for (int a = 0; a < DEPTH; a++) wr_env(a, a + 1);
      wr_len(15);
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      n_checks++;
      if (valid_out !== 1'b1 || i_out !== 0 || q_out !== 6) begin
         n_fail++;
         $display("FAIL mid_sample5: valid=%b i=%0d q=%0d, want 1 0 6", valid_out, i_out, q_out);
      end
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if ({busy, valid_out, start_count, finish_count} !== 4'b0 || i_out !== 0 || q_out !== 0) begin
         n_fail++;
         $display("FAIL mid_async_reset: busy=%b valid=%b start=%b finish=%b i=%0d q=%0d, want all 0",
                  busy, valid_out, start_count, finish_count, i_out, q_out);
      end
      tick();
      rst = 1'b0;
      model_reset();
      tick();
      n_checks++;
      if (finish_count !== 1'b0 || valid_out !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_no_finish: finish=%b valid=%b, want 0 0", finish_count, valid_out);
      end
      capture(1'b0, 1'b0, -1, 0, -1, 0, 0, n);
      n_checks++;
      if (n !== 16) begin
         n_fail++;
         $display("FAIL mid_after_len: got %0d, want 16", n);
      end
      for (int j = 0; j < n; j++) begin
         n_checks++;
         if (cap_i[j] !== 0 || cap_q[j] !== 0) begin
            n_fail++;
            $display("FAIL mid_after_zero[%0d]: got (%0d,%0d), want (0,0)", j, cap_i[j], cap_q[j]);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_basic();
      test_saturation();
      test_len_zero();
      test_trigger_held();
      test_length_write_blocked();
      test_collision();
      test_random();
      test_reset_mid_pulse();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
